// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice path.
// Contents: waveform encoding, default pitch/note widths, reference
// pitch words, the note event record and the allocator FSM states.
package synth_pkg;

  localparam int unsigned PITCH_W = 12;
  localparam int unsigned NOTE_W  = 7;

  // pitch = clk/(2*256*freq) - 1 at 12 MHz
  localparam logic [PITCH_W-1:0] P_A440 = 12'd52;
  localparam logic [PITCH_W-1:0] P_A880 = 12'd26;

  typedef enum logic [1:0] {
    WF_SQUARE = 2'd0,
    WF_TRI    = 2'd1,
    WF_SINE   = 2'd2,
    WF_SAW    = 2'd3
  } waveform_t;

  typedef struct packed {
    logic                on;
    logic [NOTE_W-1:0]   note;
    logic [PITCH_W-1:0]  pitch;
    waveform_t           waveform;
  } note_event_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PROC = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/voice_allocator_select.sv
// Combinational voice lookup for the allocator.
// Ports:
//   ena_i        per-voice active flags
//   tags_i       packed per-voice note tags, voice 0 in LSBs
//   ranks_i      packed per-voice age ranks (0 youngest)
//   note_i       note tag to look up
//   hit_o/hit_idx_o    lowest-index active voice carrying note_i
//   free_o/free_idx_o  lowest-index inactive voice
//   oldest_idx_o       voice whose rank is NUM_VOICES-1
module voice_select #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_W     = 7,
  parameter int unsigned VIDX_W     = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]        ena_i,
  input  logic [NUM_VOICES*NOTE_W-1:0] tags_i,
  input  logic [NUM_VOICES*VIDX_W-1:0] ranks_i,
  input  logic [NOTE_W-1:0]            note_i,
  output logic                         hit_o,
  output logic [VIDX_W-1:0]            hit_idx_o,
  output logic                         free_o,
  output logic [VIDX_W-1:0]            free_idx_o,
  output logic [VIDX_W-1:0]            oldest_idx_o
);

  // Scan from the top index down so the lowest matching index is the last
  // one written and therefore wins.
  always_comb begin
    hit_o        = 1'b0;
    hit_idx_o    = '0;
    free_o       = 1'b0;
    free_idx_o   = '0;
    oldest_idx_o = '0;
    for (int unsigned j = 0; j < NUM_VOICES; j++) begin
      int unsigned i;
      i = NUM_VOICES - 1 - j;
      if (ena_i[i] && (tags_i[i*NOTE_W +: NOTE_W] == note_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = VIDX_W'(i);
      end
      if (!ena_i[i]) begin
        free_o     = 1'b1;
        free_idx_o = VIDX_W'(i);
      end
      if (ranks_i[i*VIDX_W +: VIDX_W] == VIDX_W'(NUM_VOICES - 1)) begin
        oldest_idx_o = VIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator in front of NUM_VOICES synth channels.
// Accepts note-on/off events over valid/ready (one event per two cycles),
// assigns note-ons to a voice (retrigger > free > steal oldest) and drives
// per-channel pitch/waveform/enable plus a one-cycle restart pulse.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ev_valid/ev_ready   event handshake
//   ev_on, ev_note, ev_pitch, ev_waveform   event payload
//   all_off             silence every voice at the next edge
//   voice_ena/_pitch/_waveform/_restart     packed per-channel outputs
//   steal, steal_voice  one-cycle pulse and index when a busy voice is taken
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PITCH_W    = 12,
  parameter int unsigned NOTE_W     = 7,
  parameter int unsigned VIDX_W     = $clog2(NUM_VOICES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_on,
  input  logic [NOTE_W-1:0]             ev_note,
  input  logic [PITCH_W-1:0]            ev_pitch,
  input  logic [1:0]                    ev_waveform,
  input  logic                          all_off,
  output logic [NUM_VOICES-1:0]         voice_ena,
  output logic [NUM_VOICES*PITCH_W-1:0] voice_pitch,
  output logic [NUM_VOICES*2-1:0]       voice_waveform,
  output logic [NUM_VOICES-1:0]         voice_restart,
  output logic                          steal,
  output logic [VIDX_W-1:0]             steal_voice
);
  import synth_pkg::*;

  alloc_state_t state_q, state_d;

  logic               ev_on_q;
  logic [NOTE_W-1:0]  ev_note_q;
  logic [PITCH_W-1:0] ev_pitch_q;
  logic [1:0]         ev_wf_q;
  logic               capture;

  logic [NUM_VOICES-1:0] ena_q, ena_d;
  logic [PITCH_W-1:0]    pitch_q [NUM_VOICES];
  logic [PITCH_W-1:0]    pitch_d [NUM_VOICES];
  logic [1:0]            wf_q    [NUM_VOICES];
  logic [1:0]            wf_d    [NUM_VOICES];
  logic [NOTE_W-1:0]     tag_q   [NUM_VOICES];
  logic [NOTE_W-1:0]     tag_d   [NUM_VOICES];
  logic [VIDX_W-1:0]     rank_q  [NUM_VOICES];
  logic [VIDX_W-1:0]     rank_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] restart_q, restart_d;
  logic                  steal_q, steal_d;
  logic [VIDX_W-1:0]     steal_voice_q, steal_voice_d;

  logic [NUM_VOICES*NOTE_W-1:0] tags_flat;
  logic [NUM_VOICES*VIDX_W-1:0] ranks_flat;
  logic                         hit, free;
  logic [VIDX_W-1:0]            hit_idx, free_idx, oldest_idx;
  logic [VIDX_W-1:0]            v;

  always_comb begin
    tags_flat  = '0;
    ranks_flat = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      tags_flat[i*NOTE_W +: NOTE_W]  = tag_q[i];
      ranks_flat[i*VIDX_W +: VIDX_W] = rank_q[i];
    end
  end

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_W     (NOTE_W),
    .VIDX_W     (VIDX_W)
  ) u_select (
    .ena_i        (ena_q),
    .tags_i       (tags_flat),
    .ranks_i      (ranks_flat),
    .note_i       (ev_note_q),
    .hit_o        (hit),
    .hit_idx_o    (hit_idx),
    .free_o       (free),
    .free_idx_o   (free_idx),
    .oldest_idx_o (oldest_idx)
  );

  always_comb begin
    state_d       = state_q;
    ena_d         = ena_q;
    pitch_d       = pitch_q;
    wf_d          = wf_q;
    tag_d         = tag_q;
    rank_d        = rank_q;
    restart_d     = '0;
    steal_d       = 1'b0;
    steal_voice_d = steal_voice_q;
    capture       = 1'b0;
    v             = '0;
    ev_ready      = (state_q == ST_IDLE) && !rst;

    case (state_q)
      ST_IDLE: begin
        if (all_off) ena_d = '0;
        if (ev_valid && ev_ready) begin
          capture = 1'b1;
          state_d = ST_PROC;
        end
      end
      ST_PROC: begin
        state_d = ST_IDLE;
        if (all_off) begin
          ena_d = '0;
        end else if (ev_on_q) begin
          if (hit) begin
            v = hit_idx;
          end else if (free) begin
            v = free_idx;
          end else begin
            v             = oldest_idx;
            steal_d       = 1'b1;
            steal_voice_d = oldest_idx;
          end
          ena_d[v]     = 1'b1;
          tag_d[v]     = ev_note_q;
          pitch_d[v]   = ev_pitch_q;
          wf_d[v]      = ev_wf_q;
          restart_d[v] = 1'b1;
          // Move v to youngest; everything younger than v ages by one, which
          // keeps the ranks a permutation.
          for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (VIDX_W'(i) == v) begin
              rank_d[i] = '0;
            end else if (rank_q[i] < rank_q[v]) begin
              rank_d[i] = rank_q[i] + VIDX_W'(1);
            end
          end
        end else if (hit) begin
          ena_d[hit_idx] = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      ev_pitch_q    <= '0;
      ev_wf_q       <= '0;
      ena_q         <= '0;
      restart_q     <= '0;
      steal_q       <= 1'b0;
      steal_voice_q <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        pitch_q[i] <= '0;
        wf_q[i]    <= '0;
        tag_q[i]   <= '0;
        rank_q[i]  <= VIDX_W'(i);
      end
    end else begin
      state_q       <= state_d;
      ena_q         <= ena_d;
      pitch_q       <= pitch_d;
      wf_q          <= wf_d;
      tag_q         <= tag_d;
      rank_q        <= rank_d;
      restart_q     <= restart_d;
      steal_q       <= steal_d;
      steal_voice_q <= steal_voice_d;
      if (capture) begin
        ev_on_q    <= ev_on;
        ev_note_q  <= ev_note;
        ev_pitch_q <= ev_pitch;
        ev_wf_q    <= ev_waveform;
      end
    end
  end

  always_comb begin
    voice_pitch    = '0;
    voice_waveform = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_pitch[i*PITCH_W +: PITCH_W] = pitch_q[i];
      voice_waveform[i*2 +: 2]          = wf_q[i];
    end
  end

  assign voice_ena     = ena_q;
  assign voice_restart = restart_q;
  assign steal         = steal_q;
  assign steal_voice   = steal_voice_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with NUM_VOICES=4.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_note;
  logic [11:0] ev_pitch;
  logic [1:0]  ev_waveform;
  logic        all_off;
  logic [3:0]  voice_ena;
  logic [47:0] voice_pitch;
  logic [7:0]  voice_waveform;
  logic [3:0]  voice_restart;
  logic        steal;
  logic [1:0]  steal_voice;

  int n_pass  = 0;
  int n_total = 0;

  voice_allocator #(
    .NUM_VOICES (4),
    .PITCH_W    (12),
    .NOTE_W     (7)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_on          (ev_on),
    .ev_note        (ev_note),
    .ev_pitch       (ev_pitch),
    .ev_waveform    (ev_waveform),
    .all_off        (all_off),
    .voice_ena      (voice_ena),
    .voice_pitch    (voice_pitch),
    .voice_waveform (voice_waveform),
    .voice_restart  (voice_restart),
    .steal          (steal),
    .steal_voice    (steal_voice)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        on;
    logic [6:0]  note;
    logic [11:0] pitch;
    logic [1:0]  wf;
    logic        aoff;
    logic [3:0]  ena;
    logic [3:0]  rs;
    logic        st;
    logic [1:0]  sv;
    int          cv;
    logic [11:0] cp;
    logic [1:0]  cw;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ev_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ev_ready) check({name, "_ready_timeout"}, 64'(ev_ready), 64'd1);
  endtask

  task automatic drive_event(input logic on, input logic [6:0] note,
                             input logic [11:0] pitch, input logic [1:0] wf);
    ev_valid    = 1'b1;
    ev_on       = on;
    ev_note     = note;
    ev_pitch    = pitch;
    ev_waveform = wf;
  endtask

  initial begin
    // note-on 60..63 fill all voices; ranks end as [3,2,1,0]
    vecs[0]  = '{1'b1, 7'd60, 12'd52, 2'd0, 1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0, 0, 12'd52, 2'd0};
    vecs[1]  = '{1'b1, 7'd61, 12'd52, 2'd0, 1'b0, 4'b0011, 4'b0010, 1'b0, 2'd0, 1, 12'd52, 2'd0};
    vecs[2]  = '{1'b1, 7'd62, 12'd52, 2'd0, 1'b0, 4'b0111, 4'b0100, 1'b0, 2'd0, 2, 12'd52, 2'd0};
    vecs[3]  = '{1'b1, 7'd63, 12'd52, 2'd0, 1'b0, 4'b1111, 4'b1000, 1'b0, 2'd0, 3, 12'd52, 2'd0};
    // steal oldest (voice 0)
    vecs[4]  = '{1'b1, 7'd64, 12'd26, 2'd2, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 0, 12'd26, 2'd2};
    // note-off 61, unmatched note-off 99, then reuse free voice 1
    vecs[5]  = '{1'b0, 7'd61, 12'd0,  2'd0, 1'b0, 4'b1101, 4'b0000, 1'b0, 2'd0, 1, 12'd52, 2'd0};
    vecs[6]  = '{1'b0, 7'd99, 12'd0,  2'd0, 1'b0, 4'b1101, 4'b0000, 1'b0, 2'd0, 1, 12'd52, 2'd0};
    vecs[7]  = '{1'b1, 7'd65, 12'd52, 2'd1, 1'b0, 4'b1111, 4'b0010, 1'b0, 2'd0, 1, 12'd52, 2'd1};
    // retrigger 62 on voice 2, then 66 steals voice 3
    vecs[8]  = '{1'b1, 7'd62, 12'd52, 2'd3, 1'b0, 4'b1111, 4'b0100, 1'b0, 2'd0, 2, 12'd52, 2'd3};
    vecs[9]  = '{1'b1, 7'd66, 12'd26, 2'd1, 1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 3, 12'd26, 2'd1};
    // all_off in PROC discards note-on 70; voice 3 keeps its pitch/waveform
    vecs[10] = '{1'b1, 7'd70, 12'd52, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 3, 12'd26, 2'd1};
    // pitch 0 is legal, lowest free voice is 0
    vecs[11] = '{1'b1, 7'd71, 12'd0,  2'd1, 1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0, 0, 12'd0,  2'd1};
    // note-off of an inactive-but-tagged voice (voice 3 tag 66 was silenced)
    vecs[12] = '{1'b0, 7'd66, 12'd0,  2'd0, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0, 3, 12'd26, 2'd1};

    rst         = 1'b1;
    ev_valid    = 1'b0;
    ev_on       = 1'b0;
    ev_note     = '0;
    ev_pitch    = '0;
    ev_waveform = '0;
    all_off     = 1'b0;

    // T1: reset
    tick();
    check("rst_ready_c1", 64'(ev_ready), 64'd0);
    tick();
    check("rst_ready_c2", 64'(ev_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(ev_ready), 64'd1);
    check("post_rst_ena", 64'(voice_ena), 64'd0);
    check("post_rst_pitch", 64'(voice_pitch), 64'd0);
    check("post_rst_wf", 64'(voice_waveform), 64'd0);
    check("post_rst_restart", 64'(voice_restart), 64'd0);
    check("post_rst_steal", 64'(steal), 64'd0);
    check("post_rst_steal_voice", 64'(steal_voice), 64'd0);

    // T2..T6 table
    for (int i = 0; i < 13; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      wait_ready(nm);
      drive_event(vecs[i].on, vecs[i].note, vecs[i].pitch, vecs[i].wf);
      tick();                       // handshake edge
      ev_valid = 1'b0;
      check({nm, "_busy"}, 64'(ev_ready), 64'd0);
      all_off = vecs[i].aoff;
      tick();                       // end-of-PROC edge
      all_off = 1'b0;
      check({nm, "_ena"}, 64'(voice_ena), 64'(vecs[i].ena));
      check({nm, "_restart"}, 64'(voice_restart), 64'(vecs[i].rs));
      check({nm, "_steal"}, 64'(steal), 64'(vecs[i].st));
      if (vecs[i].st) check({nm, "_steal_voice"}, 64'(steal_voice), 64'(vecs[i].sv));
      check({nm, "_pitch"}, 64'(voice_pitch[vecs[i].cv*12 +: 12]), 64'(vecs[i].cp));
      check({nm, "_wf"}, 64'(voice_waveform[vecs[i].cv*2 +: 2]), 64'(vecs[i].cw));
      check({nm, "_ready"}, 64'(ev_ready), 64'd1);
      tick();
      check({nm, "_restart_1cyc"}, 64'(voice_restart), 64'd0);
      check({nm, "_steal_1cyc"}, 64'(steal), 64'd0);
    end

    // all_off in IDLE with a same-cycle handshake: silence now, event still applied
    wait_ready("idle_aoff");
    drive_event(1'b1, 7'd72, 12'd52, 2'd2);
    all_off = 1'b1;
    tick();
    ev_valid = 1'b0;
    all_off  = 1'b0;
    check("idle_aoff_ena_cleared", 64'(voice_ena), 64'd0);
    tick();
    check("idle_aoff_ena_alloc", 64'(voice_ena), 64'b0001);
    check("idle_aoff_restart", 64'(voice_restart), 64'b0001);
    check("idle_aoff_wf", 64'(voice_waveform[1:0]), 64'd2);
    tick();

    // rst during PROC drops the event and restores reset values
    wait_ready("rst_proc");
    drive_event(1'b1, 7'd73, 12'd99, 2'd3);
    tick();
    ev_valid = 1'b0;
    rst      = 1'b1;
    tick();
    check("rst_proc_ena", 64'(voice_ena), 64'd0);
    check("rst_proc_restart", 64'(voice_restart), 64'd0);
    check("rst_proc_pitch", 64'(voice_pitch), 64'd0);
    check("rst_proc_wf", 64'(voice_waveform), 64'd0);
    check("rst_proc_steal", 64'(steal), 64'd0);
    check("rst_proc_ready", 64'(ev_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_proc_ready_after", 64'(ev_ready), 64'd1);
    check("rst_proc_ena_after", 64'(voice_ena), 64'd0);

    // after reset, voice 0 is free again and nothing is stolen
    drive_event(1'b1, 7'd74, 12'd52, 2'd0);
    tick();
    ev_valid = 1'b0;
    tick();
    check("after_rst_alloc_ena", 64'(voice_ena), 64'b0001);
    check("after_rst_alloc_restart", 64'(voice_restart), 64'b0001);
    check("after_rst_alloc_steal", 64'(steal), 64'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
